hw_input_stencil_stream_ctrl: RTL and testbench
===============================================

# hw_input_stencil_stream_ctrl

Streaming controller directly upstream of and around `hw_input_stencil_ub` in the gaussian pipeline. It accepts the raw input image as a valid/ready pixel stream and drives the buffer's write port (`wen`, `ctrl_vars`, data). It also schedules the buffer's 9-tap read port for every 3x3 window origin, issuing each origin as soon as its last pixel is written. Each window is registered and presented to the `blur_unnormalized_stencil_1` compute stage over a valid/ready handshake.

## Interface
Parameters:
- `IMG_W`, 64: image width in pixels.
- `IMG_H`, 64: image height in pixels.
- `K`, 3: stencil size. Output extent is `(IMG_H-K+1) x (IMG_W-K+1)`, i.e. 62x62.
- `DW`, 16: pixel width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `flush`  in  1: synchronous frame abort, active-high.
- `in_valid`  in  1: input pixel valid.
- `in_ready`  out  1: controller accepts a pixel.
- `in_data`  in  DW: pixel, raster order (x fastest).
- `ub_wen`  out  1: buffer write enable.
- `ub_wr_ctrl_vars`  out  3xDW: [0]=0, [1]=y, [2]=x of the pixel being written.
- `ub_wr_data`  out  DW: equal to `in_data`.
- `ub_ren`  out  1: buffer read enable (window issue).
- `ub_rd_ctrl_vars`  out  3xDW: [0]=0, [1]=window origin y, [2]=window origin x.
- `ub_rd_data`  in  9xDW: combinational buffer read. Tap index = dy*3+dx.
- `win_valid`  out  1: window register holds data.
- `win_ready`  in  1: consumer accepts the window.
- `win_data`  out  9xDW: registered taps.
- `win_y`, `win_x`  out  DW: origin of the held window.
- `win_last`  out  1: held window is origin (61,61).
- `frame_done`  out  1: one-cycle pulse after the last window is accepted.

## Operation
- Write FSM states:
  - WRITE: `in_ready`=1.
  - HOLD: `in_ready`=0.
  - WRITE→HOLD when the accepted pixel count `wcnt` reaches IMG_W*IMG_H (4096).
  - HOLD→WRITE on the cycle after `frame_done`.
- `ub_wen` = `in_valid & in_ready`, combinational.
- `ub_wr_ctrl_vars` come from the registered write counters (wy, wx), which advance x-first and wrap x at IMG_W-1.
- `wcnt` is 13 bits, 0..4096, and increments on each accepted write.
- Read counters (ry, rx) run over 0..61 x-first.
- Dependency rule: `dep_ok` = `wcnt` > (ry+K-1)*IMG_W + rx+K-1, compared at 13-bit unsigned.
- `ub_ren` = `dep_ok & reads_pending & (!win_valid | win_ready)`, combinational.
- On `ub_ren`:
  - `win_data` <= `ub_rd_data`.
  - `win_y`/`win_x` <= ry/rx.
  - `win_last` <= (ry==61 && rx==61).
  - `win_valid` <= 1.
  - Counters advance.
  - `reads_pending` clears after issuing (61,61).
- `win_valid` clears on `win_ready` with no new issue. Issue and accept in the same cycle keeps `win_valid`=1 and loads the new window, giving 1 window/cycle sustained.
- `frame_done` pulses one cycle after the `win_valid & win_ready & win_last` handshake. On that pulse: `wcnt`, wy, wx, ry, rx are zeroed and `reads_pending` is set.
- Input writes for the next frame are blocked until `frame_done`, so no pixel is overwritten while still needed.
- `flush`:
  - Same-cycle effect: `in_ready`, `ub_wen`, `ub_ren` are forced to 0 and any handshake that cycle is ignored.
  - Next edge: all counters are zeroed, `win_valid`=0, the FSM returns to WRITE, and `reads_pending` is set.
  - `frame_done` does not pulse.

## Timing
- Reset values: all counters 0, FSM in WRITE, `win_valid`/`win_last`/`frame_done` 0, `win_data`/`win_y`/`win_x` 0.
- `in_ready` = (FSM==WRITE) & ~`rst` & ~`flush`.
- `ub_wen`=`ub_ren`=0 while `rst` is high.
- The buffer write lands at the clock edge. A pixel written at edge t is readable from cycle t+1.
- Latency from accepting pixel (2,2) at edge t to issuing origin (0,0): `wcnt`=131 after t, `ub_ren` in cycle t+1, `win_valid` after edge t+1.
- Steady state: after row y+2 begins filling, origin (y,x) issues the cycle after pixel (y+2,x+2) is written.
- Windows for row 61 drain in HOLD at the consumer rate.
- Asynchronous reset mid-frame: every output returns to its reset value immediately. No partial window is retained.

## Test plan
- Full frame with `in_valid`=1 and `win_ready`=1, in_data=y*64+x:
  - exactly 4096 writes and 3844 windows;
  - window (10,20) tap 4 = 11*64+21 = 725;
  - `win_last` set only on (61,61);
  - `frame_done` pulses once, 1 cycle after the final accept.
- Dependency check: stall input after 130 pixels → `ub_ren` stays 0. Send the 131st pixel → origin (0,0) issues the next cycle with taps 0,1,2,64,65,66,128,129,130.
- Backpressure: hold `win_ready`=0 for 5 cycles mid-row → `win_data`/`win_x`/`win_y` stable, `ub_ren`=0. On release, no window is skipped or duplicated (rx sequence is contiguous).
- Frame boundary: after 4096 writes `in_ready`=0 with `in_valid` held high. `in_ready` returns to 1 the cycle after `frame_done`, and the second frame's first `ub_wr_ctrl_vars` = (0,0,0).
- Flush at pixel 2000, in the same cycle as `in_valid`=1 → no write that cycle, `win_valid`=0 the next cycle, no `frame_done`. A fresh frame then completes normally.
- Asynchronous reset pulse between clock edges mid-frame → `win_valid`/`frame_done` low and `ub_wen`/`ub_ren` low during reset. The next full frame output matches the first scenario.

Source files
------------

// File: rtl/hw_input_stencil_stream_ctrl_if.sv
// Handshake and buffer-port bundle for the input stencil stream controller.
// master = controller side, slave = pixel source / line buffer / consumer side.
interface hw_input_stencil_stream_ctrl_if #(
    parameter int unsigned DW = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic                  ub_wen;
    logic [2:0][DW-1:0]    ub_wr_ctrl_vars;
    logic [DW-1:0]         ub_wr_data;
    logic                  ub_ren;
    logic [2:0][DW-1:0]    ub_rd_ctrl_vars;
    logic [8:0][DW-1:0]    ub_rd_data;
    logic                  win_valid;
    logic                  win_ready;
    logic [8:0][DW-1:0]    win_data;
    logic [DW-1:0]         win_y;
    logic [DW-1:0]         win_x;
    logic                  win_last;
    logic                  frame_done;

    modport master (
        input  in_valid, in_data, ub_rd_data, win_ready,
        output in_ready, ub_wen, ub_wr_ctrl_vars, ub_wr_data, ub_ren, ub_rd_ctrl_vars,
               win_valid, win_data, win_y, win_x, win_last, frame_done
    );

    modport slave (
        output in_valid, in_data, ub_rd_data, win_ready,
        input  in_ready, ub_wen, ub_wr_ctrl_vars, ub_wr_data, ub_ren, ub_rd_ctrl_vars,
               win_valid, win_data, win_y, win_x, win_last, frame_done
    );
endinterface

// File: rtl/hw_input_stencil_stream_ctrl.sv
// Writes a raster pixel stream into the stencil line buffer and issues each
// 3x3 window origin as soon as its last pixel has landed, one window per cycle.
module hw_input_stencil_stream_ctrl #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned K     = 3,
    parameter int unsigned DW    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    hw_input_stencil_stream_ctrl_if.master bus
);
    localparam int unsigned NPIX = IMG_W * IMG_H;
    localparam int unsigned CW   = $clog2(NPIX + 1);
    localparam int unsigned XW   = $clog2(IMG_W);
    localparam int unsigned YW   = $clog2(IMG_H);
    localparam int unsigned OW   = IMG_W - K + 1;
    localparam int unsigned OH   = IMG_H - K + 1;

    typedef enum logic {S_WRITE = 1'b0, S_HOLD = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_wcnt;
    logic [YW-1:0]       r_wy;
    logic [XW-1:0]       r_wx;
    logic [YW-1:0]       r_ry;
    logic [XW-1:0]       r_rx;
    logic                r_pending;
    logic                r_win_valid;
    logic                r_win_last;
    logic                r_frame_done;
    logic [8:0][DW-1:0]  r_win_data;
    logic [DW-1:0]       r_win_y;
    logic [DW-1:0]       r_win_x;

    logic                w_in_ready;
    logic                w_wen;
    logic                w_ren;
    logic                w_accept;
    logic                w_rd_last;
    logic [CW-1:0]       w_dep_thr;
    logic                w_dep_ok;

    assign w_in_ready = (r_state == S_WRITE) & ~rst & ~flush;
    assign w_wen      = bus.in_valid & w_in_ready;

    // Origin (ry,rx) is complete once pixel (ry+K-1, rx+K-1) has been written.
    assign w_dep_thr  = (CW'(r_ry) + CW'(K - 1)) * CW'(IMG_W) + CW'(r_rx) + CW'(K - 1);
    assign w_dep_ok   = r_wcnt > w_dep_thr;
    assign w_ren      = w_dep_ok & r_pending & (~r_win_valid | bus.win_ready) & ~rst & ~flush;
    assign w_accept   = r_win_valid & bus.win_ready & ~flush;
    assign w_rd_last  = (r_ry == YW'(OH - 1)) && (r_rx == XW'(OW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_WRITE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WRITE: if (w_wen && r_wcnt == CW'(NPIX - 1)) w_state_nxt = S_HOLD;
            S_HOLD:  if (r_frame_done) w_state_nxt = S_WRITE;
            default: w_state_nxt = S_WRITE;
        endcase
        if (flush) w_state_nxt = S_WRITE;
    end

    // Write-side raster position and accepted-pixel count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
            r_wy   <= '0;
            r_wx   <= '0;
        end else if (flush || r_frame_done) begin
            r_wcnt <= '0;
            r_wy   <= '0;
            r_wx   <= '0;
        end else if (w_wen) begin
            r_wcnt <= r_wcnt + CW'(1);
            if (r_wx == XW'(IMG_W - 1)) begin
                r_wx <= '0;
                r_wy <= r_wy + YW'(1);
            end else begin
                r_wx <= r_wx + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ry      <= '0;
            r_rx      <= '0;
            r_pending <= 1'b1;
        end else if (flush || r_frame_done) begin
            r_ry      <= '0;
            r_rx      <= '0;
            r_pending <= 1'b1;
        end else if (w_ren) begin
            if (w_rd_last) r_pending <= 1'b0;
            if (r_rx == XW'(OW - 1)) begin
                r_rx <= '0;
                r_ry <= r_ry + YW'(1);
            end else begin
                r_rx <= r_rx + XW'(1);
            end
        end
    end

    // Output window register: a new issue may replace a window in its accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_valid  <= 1'b0;
            r_win_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_data   <= '0;
            r_win_y      <= '0;
            r_win_x      <= '0;
        end else if (flush) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept & r_win_last;
            if (w_ren) begin
                r_win_valid <= 1'b1;
                r_win_data  <= bus.ub_rd_data;
                r_win_y     <= DW'(r_ry);
                r_win_x     <= DW'(r_rx);
                r_win_last  <= w_rd_last;
            end else if (w_accept) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.ub_wen          = w_wen;
    assign bus.ub_wr_ctrl_vars = {DW'(r_wx), DW'(r_wy), DW'(0)};
    assign bus.ub_wr_data      = bus.in_data;
    assign bus.ub_ren          = w_ren;
    assign bus.ub_rd_ctrl_vars = {DW'(r_rx), DW'(r_ry), DW'(0)};
    assign bus.win_valid       = r_win_valid;
    assign bus.win_data        = r_win_data;
    assign bus.win_y           = r_win_y;
    assign bus.win_x           = r_win_x;
    assign bus.win_last        = r_win_last;
    assign bus.frame_done      = r_frame_done;
endmodule

// File: tb/tb_hw_input_stencil_stream_ctrl.sv
// Bench for hw_input_stencil_stream_ctrl: models the line buffer and predicts
// writes, window issue, window contents and frame_done from the image rules.
module tb_hw_input_stencil_stream_ctrl;
    localparam int unsigned IMG_W = 64;
    localparam int unsigned IMG_H = 64;
    localparam int unsigned K     = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned OW    = IMG_W - K + 1;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned NWIN  = OW * (IMG_H - K + 1);
    localparam int          BUDGET = 20000;

    logic clk;
    logic rst;
    logic flush;

    hw_input_stencil_stream_ctrl_if #(.DW(DW)) bus();

    hw_input_stencil_stream_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [NPIX];
    logic [DW-1:0] img [NPIX];

    // Line buffer: combinational 9-tap read at the issued origin.
    always_comb begin
        for (int t = 0; t < 9; t++) begin
            bus.ub_rd_data[t] = mem[((int'(bus.ub_rd_ctrl_vars[1]) + t / 3) * IMG_W
                                     + int'(bus.ub_rd_ctrl_vars[2]) + t % 3) % NPIX];
        end
    end

    int vectors, errors;
    int wc, rd_idx, ey, ex, n_fd;
    bit ev, efd, det_frame;
    int obs_wen, obs_hs, obs_fd;

    task automatic chk(input string tag, input logic [143:0] act, input logic [143:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [143:0] taps(input int y, input int x);
        logic [143:0] r;
        for (int t = 0; t < 9; t++) r[t*DW +: DW] = img[(y + t / 3) * IMG_W + x + t % 3];
        return r;
    endfunction

    task automatic model_reset();
        wc = 0; rd_idx = 0; ev = 0; efd = 0; ey = 0; ex = 0;
    endtask

    task automatic tick();
        bit e_rdy, e_wen, e_ren, hs, fd_cur, d_wen;
        int oy, ox, thr, d_adr;
        logic [DW-1:0] in_d, d_dat;
        @(negedge clk);
        oy     = rd_idx / OW;
        ox     = rd_idx % OW;
        thr    = (oy + K - 1) * IMG_W + ox + K - 1;
        e_rdy  = !flush && wc < NPIX;
        e_wen  = e_rdy && bus.in_valid;
        e_ren  = !flush && rd_idx < NWIN && wc > thr && (!ev || bus.win_ready);
        hs     = ev && bus.win_ready && !flush;
        fd_cur = efd;
        in_d   = bus.in_data;
        chk("in_ready",   144'(bus.in_ready),   144'(e_rdy));
        chk("ub_wen",     144'(bus.ub_wen),     144'(e_wen));
        chk("ub_ren",     144'(bus.ub_ren),     144'(e_ren));
        chk("win_valid",  144'(bus.win_valid),  144'(ev));
        chk("frame_done", 144'(bus.frame_done), 144'(fd_cur));
        if (e_wen) begin
            chk("wr_ctrl_vars", 144'(bus.ub_wr_ctrl_vars),
                144'({DW'(wc % IMG_W), DW'(wc / IMG_W), DW'(0)}));
            chk("wr_data", 144'(bus.ub_wr_data), 144'(in_d));
        end
        if (e_ren)
            chk("rd_ctrl_vars", 144'(bus.ub_rd_ctrl_vars), 144'({DW'(ox), DW'(oy), DW'(0)}));
        if (ev) begin
            chk("win_y",    144'(bus.win_y),    144'(ey));
            chk("win_x",    144'(bus.win_x),    144'(ex));
            chk("win_last", 144'(bus.win_last), 144'(ey == 61 && ex == 61));
            chk("win_data", 144'(bus.win_data), taps(ey, ex));
        end
        if (hs && det_frame && ey == 10 && ex == 20)
            chk("tap4_10_20", 144'(bus.win_data[4]), 144'(725));
        d_wen = bus.ub_wen;
        d_adr = int'(bus.ub_wr_ctrl_vars[1]) * IMG_W + int'(bus.ub_wr_ctrl_vars[2]);
        d_dat = bus.ub_wr_data;
        obs_wen += int'(bus.ub_wen);
        obs_hs  += int'(bus.win_valid && bus.win_ready && !flush);
        obs_fd  += int'(bus.frame_done);
        @(posedge clk);
        #1;
        if (d_wen && d_adr < NPIX) mem[d_adr] = d_dat;
        if (fd_cur) n_fd++;
        if (flush) begin
            model_reset();
        end else begin
            efd = hs && ey == 61 && ex == 61;
            if (e_wen) begin img[wc] = in_d; wc++; end
            if (fd_cur) begin wc = 0; rd_idx = 0; end
            if (e_ren) begin ev = 1; ey = oy; ex = ox; rd_idx++; end
            else if (hs) ev = 0;
        end
    endtask

    // Called just after a rising edge: reset is raised and dropped before the next falling edge.
    task automatic async_reset_pulse();
        #1 rst = 1'b1;
        #1;
        chk("rst_win_valid",  144'(bus.win_valid),  144'(0));
        chk("rst_frame_done", 144'(bus.frame_done), 144'(0));
        chk("rst_ub_wen",     144'(bus.ub_wen),     144'(0));
        chk("rst_ub_ren",     144'(bus.ub_ren),     144'(0));
        chk("rst_in_ready",   144'(bus.in_ready),   144'(0));
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic run_frame(input bit det, input int vprob, input int rprob, input int stall_at,
                             input int hold_at, input int flush_at, input int rst_at);
        int cyc, stall_left, hold_left, fd0;
        bit stop;
        cyc = 0; stall_left = -1; hold_left = -1; fd0 = n_fd; stop = 0;
        det_frame = det; obs_wen = 0; obs_hs = 0; obs_fd = 0;
        while (!stop && n_fd == fd0 && cyc < BUDGET) begin
            flush        = 1'b0;
            bus.in_valid = ($urandom_range(99) < vprob);
            if (stall_at >= 0 && wc == stall_at && stall_left < 0) stall_left = 8;
            if (stall_left > 0) begin bus.in_valid = 1'b0; stall_left--; end
            bus.in_data   = det ? DW'(wc) : DW'($urandom);
            bus.win_ready = ($urandom_range(99) < rprob);
            if (hold_at >= 0 && rd_idx == hold_at && hold_left < 0) hold_left = 5;
            if (hold_left > 0) begin bus.win_ready = 1'b0; hold_left--; end
            if (flush_at >= 0 && wc == flush_at) begin
                flush = 1'b1; bus.in_valid = 1'b1; stop = 1;
            end
            tick();
            cyc++;
            if (rst_at >= 0 && wc == rst_at && !stop) begin
                async_reset_pulse();
                stop = 1;
            end
        end
        flush = 1'b0;
        if (cyc >= BUDGET) begin
            chk("frame_timeout", 144'(cyc), 144'(0));
        end else if (!stop) begin
            chk("frame_writes",      144'(obs_wen), 144'(NPIX));
            chk("frame_windows",     144'(obs_hs),  144'(NWIN));
            chk("frame_done_pulses", 144'(obs_fd),  144'(1));
        end
    endtask

    initial begin
        vectors = 0; errors = 0; n_fd = 0;
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = '0; bus.win_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",   144'(bus.in_ready),   144'(0));
        chk("reset_ub_wen",     144'(bus.ub_wen),     144'(0));
        chk("reset_ub_ren",     144'(bus.ub_ren),     144'(0));
        chk("reset_win_valid",  144'(bus.win_valid),  144'(0));
        chk("reset_win_last",   144'(bus.win_last),   144'(0));
        chk("reset_frame_done", 144'(bus.frame_done), 144'(0));
        chk("reset_win_data",   144'(bus.win_data),   144'(0));
        chk("reset_win_y",      144'(bus.win_y),      144'(0));
        chk("reset_win_x",      144'(bus.win_x),      144'(0));
        #2 rst = 1'b0;

        run_frame(1'b1, 100, 100, 130, 640, -1, -1);
        run_frame(1'b0, 70, 60, -1, -1, -1, -1);
        run_frame(1'b0, 100, 80, -1, -1, 2000, -1);
        run_frame(1'b0, 80, 70, -1, -1, -1, -1);
        run_frame(1'b0, 70, 90, -1, -1, -1, 1500);
        run_frame(1'b1, 100, 100, -1, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
